// File: rtl/md_scheduler_pkg.sv
// Shared encodings and defaults for the multiply/divide scheduler.
// The long-latency ops (mult/multu/div/divu) are exactly the codes with bit 2 clear.
package md_scheduler_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;
  localparam int CNT_W_DEF    = 4;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } md_res_t;

  function automatic logic is_long_op(logic [2:0] op);
    return ~op[2];
  endfunction

  function automatic logic is_div_op(logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_scheduler_if.sv
// Stage-E issue / stage-D hazard bundle between the pipeline and the md scheduler.
interface md_scheduler_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a_val;
  logic [31:0] b_val;
  logic        md_use_D;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, a_val, b_val, md_use_D,
    input  busy, md_stall, hi, lo
  );

  modport slave (
    input  start, md_op, a_val, b_val, md_use_D,
    output busy, md_stall, hi, lo
  );
endinterface

// File: rtl/md_scheduler_md_alu.sv
// Combinational {hi,lo} result for mult/multu/div/divu; res_we_o low means
// the result must not be written back (divide by zero or non-arith op).
module md_alu
  import md_scheduler_pkg::*;
(
  input  logic [2:0]  md_op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output md_res_t     res_o,
  output logic        res_we_o
);

  logic signed [63:0] a_sx, b_sx, prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] a_s, b_s, quo_s, rem_s;
  logic        [31:0] quo_u, rem_u;
  logic               b_zero, b_neg1;

  assign a_sx   = {{32{a_i[31]}}, a_i};
  assign b_sx   = {{32{b_i[31]}}, b_i};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, a_i} * {32'd0, b_i};

  assign a_s    = a_i;
  assign b_s    = b_i;
  assign b_zero = (b_i == 32'd0);
  assign b_neg1 = (b_i == 32'hFFFF_FFFF);

  // x / -1 is a plain negate; this sidesteps the INT_MIN / -1 overflow trap.
  always_comb begin
    quo_s = 32'sd0;
    rem_s = 32'sd0;
    quo_u = 32'd0;
    rem_u = 32'd0;
    if (b_neg1) begin
      quo_s = 32'sd0 - a_s;
    end else if (!b_zero) begin
      quo_s = a_s / b_s;
      rem_s = a_s % b_s;
    end
    if (!b_zero) begin
      quo_u = a_i / b_i;
      rem_u = a_i % b_i;
    end
  end

  always_comb begin
    res_o    = '0;
    res_we_o = 1'b0;
    case (md_op_i)
      MD_MULT: begin
        res_o    = prod_s;
        res_we_o = 1'b1;
      end
      MD_MULTU: begin
        res_o    = prod_u;
        res_we_o = 1'b1;
      end
      MD_DIV: begin
        res_o.hi = rem_s;
        res_o.lo = quo_s;
        res_we_o = !b_zero;
      end
      MD_DIVU: begin
        res_o.hi = rem_u;
        res_o.lo = quo_u;
        res_we_o = !b_zero;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_scheduler.sv
// Multiply/divide scheduler: owns HI/LO, models op occupancy with a down
// counter, and requests a D-stage stall while the unit is starting or busy.
module md_scheduler
  import md_scheduler_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = CNT_W_DEF   // 2**CNT_W must exceed both latencies
) (
  input logic           clk,
  input logic           reset,
  md_scheduler_if.slave bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  md_res_t          pend_q, pend_d;
  logic             pend_we_q, pend_we_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  md_res_t alu_res;
  logic    alu_we;

  md_alu u_alu (
    .md_op_i  (bus.md_op),
    .a_i      (bus.a_val),
    .b_i      (bus.b_val),
    .res_o    (alu_res),
    .res_we_o (alu_we)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pend_q    <= '0;
      pend_we_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pend_we_q <= pend_we_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  // A start seen in RUN is dropped entirely; the hazard unit should never let it through.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    pend_we_d = pend_we_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (is_long_op(bus.md_op)) begin
            state_d   = S_RUN;
            cnt_d     = is_div_op(bus.md_op) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
            pend_d    = alu_res;
            pend_we_d = alu_we;
          end else if (bus.md_op == MD_MTHI) begin
            hi_d = bus.a_val;
          end else if (bus.md_op == MD_MTLO) begin
            lo_d = bus.a_val;
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          if (pend_we_q) begin
            hi_d = pend_q.hi;
            lo_d = pend_q.lo;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy     = (state_q == S_RUN);
  assign bus.md_stall = bus.md_use_D & (bus.start | bus.busy);
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_md_scheduler.sv
// Self-checking bench for md_scheduler: vector table, hand-built corner
// sequences, then random ops against a 64-bit arithmetic reference model.
module tb_md_scheduler;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] m_hi, m_lo;

  md_scheduler_if ifc ();

  md_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
    int          ebusy;
  } vec_t;

  vec_t vt[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural rules.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       inout logic [31:0] h, inout logic [31:0] l, output int lat);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    lat = 0;
    case (op)
      3'd0: begin p = sa * sb; {h, l} = p; lat = 5; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; {h, l} = p; lat = 5; end
      3'd2: begin
        lat = 10;
        if (b != 0) begin q = sa / sb; r = sa % sb; l = q[31:0]; h = r[31:0]; end
      end
      3'd3: begin
        lat = 10;
        if (b != 0) begin l = a / b; h = a % b; end
      end
      3'd4: h = a;
      3'd5: l = a;
      default: ;
    endcase
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int nb, output bit early);
    logic [31:0] h0, l0;
    h0 = ifc.hi;
    l0 = ifc.lo;
    early = 1'b0;
    ifc.start = 1'b1;
    ifc.md_op = op;
    ifc.a_val = a;
    ifc.b_val = b;
    tick();
    ifc.start = 1'b0;
    ifc.a_val = $urandom;
    ifc.b_val = $urandom;
    nb = 0;
    while (ifc.busy && nb < 40) begin
      if (ifc.hi !== h0 || ifc.lo !== l0) early = 1'b1;
      nb++;
      tick();
    end
  endtask

  initial begin
    int nb, s, lat;
    bit early;
    logic [2:0]  op;
    logic [31:0] a, b;

    vt[0] = '{3'd0, 32'hFFFF_FFFE, 32'd3,          32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
    vt[1] = '{3'd1, 32'hFFFF_FFFE, 32'd3,          32'h0000_0002, 32'hFFFF_FFFA, 5};
    vt[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vt[3] = '{3'd3, 32'd7,         32'd0,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vt[4] = '{3'd3, 32'd100,       32'd7,          32'd2,         32'd14,        10};
    vt[5] = '{3'd0, 32'h8000_0000, 32'h8000_0000,  32'h4000_0000, 32'd0,         5};
    vt[6] = '{3'd6, 32'd1,         32'd2,          32'h4000_0000, 32'd0,         0};
    vt[7] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         32'h8000_0000, 10};
    vt[8] = '{3'd4, 32'h1234_5678, 32'd9,          32'h1234_5678, 32'h8000_0000, 0};
    vt[9] = '{3'd2, 32'd7,         32'hFFFF_FFFE,  32'd1,         32'hFFFF_FFFD, 10};

    reset = 1'b1;
    ifc.start = 1'b0; ifc.md_op = 3'd0; ifc.a_val = '0; ifc.b_val = '0; ifc.md_use_D = 1'b0;
    #1;
    chk("rst_busy", ifc.busy, 0);
    chk("rst_hi", ifc.hi, 0);
    chk("rst_lo", ifc.lo, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      do_op(vt[i].op, vt[i].a, vt[i].b, nb, early);
      chk($sformatf("vec%0d_busy", i), nb, vt[i].ebusy);
      chk($sformatf("vec%0d_early", i), early, 0);
      chk($sformatf("vec%0d_hi", i), ifc.hi, vt[i].ehi);
      chk($sformatf("vec%0d_lo", i), ifc.lo, vt[i].elo);
    end

    // mthi then mtlo on back-to-back cycles
    ifc.start = 1'b1; ifc.md_op = 3'd4; ifc.a_val = 32'h1234_5678;
    tick();
    chk("mthi_hi", ifc.hi, 32'h1234_5678);
    chk("mthi_lo", ifc.lo, 32'hFFFF_FFFD);
    chk("mthi_busy", ifc.busy, 0);
    ifc.md_op = 3'd5; ifc.a_val = 32'h9ABC_DEF0;
    tick();
    ifc.start = 1'b0;
    chk("mtlo_lo", ifc.lo, 32'h9ABC_DEF0);
    chk("mtlo_hi", ifc.hi, 32'h1234_5678);
    chk("mtlo_busy", ifc.busy, 0);

    // stall with a D-stage user behind the op
    ifc.md_use_D = 1'b1;
    #1 chk("stall_idle", ifc.md_stall, 0);
    ifc.start = 1'b1; ifc.md_op = 3'd0; ifc.a_val = 32'd3; ifc.b_val = 32'd4;
    #1 chk("stall_start", ifc.md_stall, 1);
    tick();
    ifc.start = 1'b0;
    s = 0; nb = 0;
    while (ifc.busy && nb < 40) begin
      if (ifc.md_stall) s++;
      nb++;
      tick();
    end
    chk("stall_cycles", s, 5);
    chk("stall_after", ifc.md_stall, 0);
    chk("stall_lo", ifc.lo, 32'd12);

    ifc.md_use_D = 1'b0;
    ifc.start = 1'b1; ifc.md_op = 3'd0;
    #1 s = ifc.md_stall ? 1 : 0;
    tick();
    ifc.start = 1'b0;
    nb = 0;
    while (ifc.busy && nb < 40) begin
      if (ifc.md_stall) s++;
      nb++;
      tick();
    end
    chk("nostall_cycles", s, 0);
    chk("nostall_busy", nb, 5);

    // start of a div while a mult is in flight is dropped
    ifc.start = 1'b1; ifc.md_op = 3'd0; ifc.a_val = 32'd5; ifc.b_val = 32'd6;
    tick();
    ifc.start = 1'b0;
    tick();
    ifc.start = 1'b1; ifc.md_op = 3'd2; ifc.a_val = 32'd100; ifc.b_val = 32'd3;
    tick();
    ifc.start = 1'b0;
    nb = 2;
    while (ifc.busy && nb < 40) begin
      nb++;
      tick();
    end
    chk("illegal_busy", nb, 5);
    chk("illegal_hi", ifc.hi, 32'd0);
    chk("illegal_lo", ifc.lo, 32'd30);
    tick();
    chk("illegal_idle", ifc.busy, 0);

    // reset two cycles into a mult
    ifc.start = 1'b1; ifc.md_op = 3'd0; ifc.a_val = 32'd7; ifc.b_val = 32'd9;
    tick();
    ifc.start = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("rstmid_busy", ifc.busy, 0);
    chk("rstmid_hi", ifc.hi, 0);
    chk("rstmid_lo", ifc.lo, 0);
    #12 reset = 1'b0;
    repeat (8) tick();
    chk("rstmid_late_busy", ifc.busy, 0);
    chk("rstmid_late_hi", ifc.hi, 0);
    chk("rstmid_late_lo", ifc.lo, 0);

    m_hi = '0;
    m_lo = '0;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 16));
        default: b = $urandom;
      endcase
      model(op, a, b, m_hi, m_lo, lat);
      do_op(op, a, b, nb, early);
      chk($sformatf("rnd%0d_op%0d_busy", i, op), nb, lat);
      chk($sformatf("rnd%0d_op%0d_early", i, op), early, 0);
      chk($sformatf("rnd%0d_op%0d_hilo", i, op), {ifc.hi, ifc.lo}, {m_hi, m_lo});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/md_scheduler.md
Name: md_scheduler

Overview:
- Multiply/divide scheduling unit for the 5-stage pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo issued from stage E and owns the HI/LO registers.
- Models multi-cycle occupancy with a busy counter.
- Drives a stall request to the hazard controller so that any stage-D instruction touching HI/LO or the unit is held until the operation retires.

Parameters:
- MULT_LAT, 5: busy cycles for mult/multu after the start cycle.
- DIV_LAT, 10: busy cycles for div/divu after the start cycle.
- CNT_W, 4: counter width; must satisfy 2^CNT_W > max(MULT_LAT, DIV_LAT).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  stage E holds a valid md instruction this cycle
- md_op  input  3  operation select: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; others are no-op
- a_val  input  32  forwarded rs operand (stage E, post-forwarding)
- b_val  input  32  forwarded rt operand (stage E, post-forwarding)
- md_use_D  input  1  stage-D instruction is mult/div/mthi/mtlo/mfhi/mflo
- busy  output  1  operation in flight
- md_stall  output  1  stall request to hazard controller (freeze PC/D, clear E)
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset: asynchronous. State IDLE, counter 0, busy 0, hi 0, lo 0, pending result 0. Reset mid-operation abandons the operation; HI/LO end at 0.
- States:
  - IDLE -> RUN on start with md_op in {0..3}.
  - RUN -> IDLE when counter reaches 1 at a clock edge.
- Start edge, ops 0..3:
  - Compute the 64-bit result and latch it into the pending register.
  - mult: signed a_val*b_val. multu: unsigned a_val*b_val.
  - div: signed; pending lo = quotient truncated toward zero, pending hi = remainder with the sign of the dividend.
  - divu: unsigned.
  - Load counter with MULT_LAT or DIV_LAT.
- RUN: counter decrements each edge. On the edge where the counter goes 1->0, hi/lo load the pending result and the state returns to IDLE.
- busy = (state == RUN), registered. Latency: mult result visible on hi/lo exactly MULT_LAT+1 edges after the start edge is sampled. busy is high for MULT_LAT cycles.
- md_stall = md_use_D & (start | busy), combinational. A stage-D user behind a starting op is stalled in the same cycle.
- Divide by zero (b_val == 0, op 2 or 3): still occupies DIV_LAT cycles; hi/lo remain unchanged at retire.
- mthi/mtlo, start in IDLE: hi (resp. lo) <= a_val at that edge. No busy, no counter change.
- start while busy: hazard stalls make this impossible by construction. If it occurs, it is ignored: no state, counter or HI/LO change. The bench asserts it never happens in integrated runs.
- start with md_op 6/7: no effect.
- Retire edge coinciding with a new start: cannot occur, since busy is still 1 on that edge. The new start is ignored per the rule above.
- hi/lo never change except at a retire edge, an mthi/mtlo edge, or reset.

Decomposition:
- Shared package/header: md_op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO), state encodings (S_IDLE, S_RUN), default latencies.
- The stage-E controller decoder emits md_op/start. The stage-D decoder emits md_use_D.
- md_stall is ORed into the hazard controller's PC_en/D_en/E_clr logic outside this block.
- One natural sub-module: md_alu, purely combinational, producing the 64-bit {hi,lo} pending result from md_op, a_val and b_val.

Test Plan:
- Reset mid-run: start mult, assert reset two cycles later -> busy 0, hi 0, lo 0 immediately; no later update.
- mult, a_val=0xFFFFFFFE (-2), b_val=3 -> busy for 5 cycles; after 6th edge hi=0xFFFFFFFF, lo=0xFFFFFFFA. multu with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- div, a_val=-7 (0xFFFFFFF9), b_val=2 -> busy for 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu, a_val=7, b_val=0 -> 10 busy cycles; hi/lo keep their prior values.
- mthi a_val=0x12345678 then mtlo a_val=0x9ABCDEF0 on consecutive cycles -> hi/lo update one edge each; busy stays 0 throughout.
- Stall: start mult with md_use_D=1 in the same cycle -> md_stall=1 that cycle and for all 5 busy cycles, 0 on the cycle after retire. With md_use_D=0 -> md_stall stays 0.
- Illegal start while busy (forced): start div with different operands mid-mult -> ignored; mult result retires on schedule; busy deasserts after MULT_LAT.
